// File: rtl/add8_seq_pkg.sv
// -----------------------------------------------------------------------------
// add8_seq_pkg
// Shared types, constants and helper functions for the add8_seq_arb sequencer.
//   state_e  : sequencer FSM states (IDLE, RUN, DONE)
//   BYTE_W   : width of the shared adder slice
//   MAX_REQ  : upper bound on the number of requesters the helpers support
//   rr_pick  : round-robin search over a valid vector starting at a pointer
//   rr_next  : pointer value that follows a granted index
// -----------------------------------------------------------------------------
package add8_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {found, index}. The search visits ptr, ptr+1, ... wrapping at nreq.
  // ptr < nreq and i < nreq, so a single subtraction is enough to wrap.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input logic [3:0]         nreq);
    logic [3:0] idx;
    logic       found;
    logic [2:0] sel;
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= nreq) idx = idx - nreq;
      if (!found && (4'(i) < nreq) && valid[idx[2:0]]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [2:0] rr_next(input logic [2:0] g,
                                         input logic [3:0] nreq);
    logic [3:0] n;
    n = {1'b0, g} + 4'd1;
    return (n >= nreq) ? 3'd0 : n[2:0];
  endfunction

endpackage

// File: rtl/add8_cin.sv
// -----------------------------------------------------------------------------
// add8_cin
// Combinational 8-bit adder with carry-in, built from generate/propagate terms.
// This is the single shared arithmetic resource of add8_seq_arb.
//   a, b  : operand bytes
//   cin   : carry in
//   sum   : a + b + cin (low 8 bits)
//   cout  : carry out of bit 7
// -----------------------------------------------------------------------------
module add8_cin
  import add8_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic [BYTE_W-1:0] g;
  logic [BYTE_W-1:0] p;
  logic [BYTE_W:0]   c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[BYTE_W-1:0];
    cout = c[BYTE_W];
  end

endmodule

// File: rtl/add8_seq_arb.sv
// -----------------------------------------------------------------------------
// add8_seq_arb
// Round-robin arbiter and byte-serial sequencer around one shared 8-bit adder.
// A granted request is processed LSB byte first, one byte per cycle, with the
// carry chained through carry_q; the full result is returned on rsp_*.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. A producer holding valid keeps its payload
// stable until that edge; rsp_valid stays high and rsp_* stay stable until the
// consumer raises rsp_ready.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : per-requester request handshake (ready is one-hot/zero)
//   req_a, req_b      : packed operands, requester r at [r*W +: W]
//   req_sub           : per-requester subtract select (ADD8_SEQ_SUB_EN only)
//   rsp_valid/ready   : response handshake
//   rsp_id            : requester that owns the response
//   rsp_sum, rsp_cout : result modulo 2^W and carry out of the top byte
//   dbg_state         : current FSM state
//
// Build option: define ADD8_SEQ_SUB_EN to add req_sub. A set req_sub bit makes
// the operation A-B (B inverted, initial carry 1); rsp_cout=1 then means A>=B.
// -----------------------------------------------------------------------------
module add8_seq_arb
  import add8_seq_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int BYTES = 4,
  localparam int W     = BYTE_W * BYTES,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
`ifdef ADD8_SEQ_SUB_EN
  input  logic [NREQ-1:0]   req_sub,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_cout,
  output state_e            dbg_state
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_e                         state_q, state_d;
  logic [IDW-1:0]                 rr_ptr_q;
  logic [IDW-1:0]                 id_q;
  logic [CW-1:0]                  cnt_q;
  logic                           carry_q;
  logic [BYTES-1:0][BYTE_W-1:0]   a_q, b_q, sum_q;

  logic [MAX_REQ-1:0] valid_ext;
  logic [3:0]         pick;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic               hs;
  logic               last_byte;
  logic [W-1:0]       sel_a, sel_b;
  logic               sel_sub;
  logic [BYTE_W-1:0]  add_sum;
  logic               add_cout;

  // Arbitration: purely combinational from req_valid and rr_ptr_q.
  always_comb begin
    valid_ext            = '0;
    valid_ext[NREQ-1:0]  = req_valid;
    pick                 = rr_pick(valid_ext, 3'(rr_ptr_q), 4'(NREQ));
    grant_found          = pick[3];
    grant_idx            = IDW'(pick[2:0]);
    hs                   = (state_q == IDLE) && grant_found;
    req_ready            = '0;
    if (hs) req_ready[grant_idx] = 1'b1;
  end

  // Payload of the granted requester.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant_idx == IDW'(r)) begin
        sel_a = req_a[r*W +: W];
        sel_b = req_b[r*W +: W];
`ifdef ADD8_SEQ_SUB_EN
        sel_sub = req_sub[r];
`endif
      end
    end
  end

  assign last_byte = (cnt_q == CW'(BYTES - 1));

  add8_cin u_add8_cin (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs)        state_d = RUN;
      RUN:     if (last_byte) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (hs) begin
            a_q      <= sel_a;
            // Subtraction is folded in here: B stored inverted, carry seeded 1.
            b_q      <= sel_b ^ {W{sel_sub}};
            carry_q  <= sel_sub;
            id_q     <= grant_idx;
            cnt_q    <= '0;
            rr_ptr_q <= IDW'(rr_next(3'(grant_idx), 4'(NREQ)));
          end
        end
        RUN: begin
          sum_q[cnt_q] <= add_sum;
          carry_q      <= add_cout;
          cnt_q        <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // carry_q holds the top-byte carry for the whole of DONE.
  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_add8_seq_arb.sv
// -----------------------------------------------------------------------------
// tb_add8_seq_arb
// Bench for add8_seq_arb (NREQ=2, BYTES=4). A negedge monitor holds a
// transaction-level model: round-robin pointer, busy flag, handshake edge and
// an expected-response queue filled with A+B (or A-B) computed arithmetically.
// Define ADD8_SEQ_SUB_EN for both RTL and bench to cover subtraction.
// -----------------------------------------------------------------------------
module tb_add8_seq_arb;
  import add8_seq_pkg::*;

  localparam int NREQ  = 2;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;
  localparam int IDW   = 1;
  localparam int RW    = IDW + 1 + W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  state_e            dbg_state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  add8_seq_arb #(.NREQ(NREQ), .BYTES(BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef ADD8_SEQ_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  bit            m_busy    = 1'b0;
  int            m_ptr     = 0;
  int unsigned   m_hs_edge = 0;
  int unsigned   rsp_edge_q[$];
  int            rsp_id_log[$];
  logic [W-1:0]  last_sum;
  logic          last_cout;
  logic [IDW-1:0] last_id;

  always @(negedge clk) begin : mon
    logic [NREQ-1:0] exp_ready;
    int              g;
    logic [W-1:0]    a, b, s_sum;
    logic            s_cout, s_sub, exp_v;
    logic [W:0]      tot;
    logic [RW-1:0]   head;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_sum",   rsp_sum,   0);
      check("rst_rsp_cout",  rsp_cout,  0);
      check("rst_rsp_id",    rsp_id,    0);
      check("rst_state",     dbg_state, IDLE);
    end
    g         = -1;
    exp_ready = '0;
    if (!m_busy) begin
      for (int i = 0; i < NREQ; i++) begin
        if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    if (rst_n) begin
      if (!m_busy) begin
        check("rsp_valid_idle", rsp_valid, 0);
        check("state_idle", dbg_state, IDLE);
        if (g >= 0) begin
          a     = req_a[g*W +: W];
          b     = req_b[g*W +: W];
          s_sub = 1'b0;
`ifdef ADD8_SEQ_SUB_EN
          s_sub = req_sub[g];
`endif
          if (s_sub) begin
            s_sum  = a - b;
            s_cout = (a >= b);
          end else begin
            tot    = {1'b0, a} + {1'b0, b};
            s_sum  = tot[W-1:0];
            s_cout = tot[W];
          end
          exp_q.push_back({IDW'(g), s_cout, s_sum});
          m_ptr     = (g + 1) % NREQ;
          m_busy    = 1'b1;
          m_hs_edge = cyc + 1;
        end
      end else begin
        exp_v = (cyc >= m_hs_edge + BYTES);
        check("rsp_valid", rsp_valid, exp_v);
        check("state_busy", dbg_state, exp_v ? DONE : RUN);
        if (exp_v && rsp_valid && exp_q.size() > 0) begin
          head = exp_q[0];
          check("rsp_sum",  rsp_sum,  head[W-1:0]);
          check("rsp_cout", rsp_cout, head[W]);
          check("rsp_id",   rsp_id,   head[RW-1 -: IDW]);
          if (cyc == m_hs_edge + BYTES) begin
            rsp_edge_q.push_back(cyc);
            rsp_id_log.push_back(int'(rsp_id));
          end
          if (rsp_ready) begin
            last_sum  = rsp_sum;
            last_cout = rsp_cout;
            last_id   = rsp_id;
            void'(exp_q.pop_front());
            m_busy = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int bound);
    int k;
    k = 0;
    while (m_busy && k < bound) begin
      tick();
      k++;
    end
    if (m_busy) check("idle_timeout", 1, 0);
  endtask

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bit got;
    got = 1'b0;
    req_valid[r]     = 1'b1;
    req_a[r*W +: W]  = a;
    req_b[r*W +: W]  = b;
    req_sub[r]       = sub;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[r]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("send_timeout", 0, 1);
    tick();
    // Payload changes after the handshake must not disturb the operation.
    req_valid[r]    = 1'b0;
    req_a[r*W +: W] = $urandom();
    req_b[r*W +: W] = $urandom();
    req_sub[r]      = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- test sequence ----------------
  logic [W-1:0] held_sum;
  bit           got_v;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed arithmetic cases
    send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_idle(50);
    check("single_sum",  last_sum,  32'h0000_0100);
    check("single_cout", last_cout, 0);
    check("single_id",   last_id,   0);

    send(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_idle(50);
    check("ripple_sum",  last_sum,  32'h0000_0000);
    check("ripple_cout", last_cout, 1);
    check("ripple_id",   last_id,   1);

    send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_idle(50);
    check("max_sum",  last_sum,  32'hFFFF_FFFE);
    check("max_cout", last_cout, 1);

    send(1, 32'h8000_7F00, 32'h8000_0100, 1'b0);
    wait_idle(50);
    check("mid_sum",  last_sum,  32'h0000_8000);
    check("mid_cout", last_cout, 1);

    // Fairness: both requesters continuously valid
    do_reset();
    rsp_edge_q.delete();
    rsp_id_log.delete();
    req_valid = '1;
    for (int k = 0; k < 80 && rsp_edge_q.size() < 5; k++) begin
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      tick();
    end
    req_valid = '0;
    wait_idle(50);
    check("fair_count", 64'(rsp_edge_q.size() >= 4), 1);
    if (rsp_edge_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("fair_id_order", rsp_id_log[i], i % 2);
      for (int i = 1; i < 4; i++) check("fair_spacing", rsp_edge_q[i] - rsp_edge_q[i-1], BYTES + 2);
    end

    // Backpressure: response held for 10 cycles, other requester kept waiting
    rsp_ready = 1'b0;
    send(0, 32'h1357_9BDF, 32'h0246_8ACE, 1'b0);
    req_valid[1]   = 1'b1;
    req_a[W +: W]  = 32'h0000_0010;
    req_b[W +: W]  = 32'h0000_0020;
    got_v = 1'b0;
    for (int k = 0; k < 20 && !got_v; k++) begin
      @(negedge clk);
      got_v = rsp_valid;
    end
    check("bp_rsp_seen", got_v, 1);
    held_sum = rsp_sum;
    repeat (10) tick();
    @(negedge clk);
    check("bp_hold_valid", rsp_valid, 1);
    check("bp_hold_sum",   rsp_sum,   held_sum);
    check("bp_ready_low",  req_ready, 0);
    tick();
    rsp_ready = 1'b1;
    send(1, 32'h0000_0010, 32'h0000_0020, 1'b0);
    wait_idle(50);
    check("bp_next_sum", last_sum, 32'h0000_0030);
    check("bp_next_id",  last_id,  1);

    // Reset in the middle of RUN: operation dropped, no response
    send(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rsp_valid", rsp_valid, 0);
    check("midrun_state",     dbg_state, IDLE);
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    send(1, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_idle(50);
    check("post_rst_sum", last_sum, 32'h2345_6789);
    check("post_rst_id",  last_id,  1);

`ifdef ADD8_SEQ_SUB_EN
    send(0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    wait_idle(50);
    check("sub_neg_sum",  last_sum,  32'hFFFF_FFFE);
    check("sub_neg_cout", last_cout, 0);
    send(1, 32'h0000_0007, 32'h0000_0005, 1'b1);
    wait_idle(50);
    check("sub_pos_sum",  last_sum,  32'h0000_0002);
    check("sub_pos_cout", last_cout, 1);
`endif

    // Random traffic with random backpressure
    for (int k = 0; k < 600; k++) begin
      req_valid = NREQ'($urandom_range(0, 3));
      req_a     = {rand_op(), rand_op()};
      req_b     = {rand_op(), rand_op()};
`ifdef ADD8_SEQ_SUB_EN
      req_sub   = NREQ'($urandom_range(0, 3));
`endif
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(50);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
